// File: rtl/bird_motion.sv
// bird_motion: SpacyBird vertical physics. Integrates gravity and flap
// impulses once per frame tick, clamps at ceiling and ground, and owns the
// bird-dead flag. After a pipe hit the bird falls to the ground and freezes.
//
// Ports:
//   iClk         system clock
//   iRstN        asynchronous active-low reset
//   iBirdRst     synchronous respawn request (highest priority)
//   iBirdWait    freeze request; holds state and discards flaps
//   iFrameTick   one-cycle pulse per video frame
//   iFlapPressed one-cycle debounced flap pulse
//   iPipeHit     level, bird overlaps a pipe
//   oBirdY       bird top edge position (registered)
//   oBirdVel     signed velocity, positive = down (registered)
//   oBirdDead    bird is dying or grounded (registered)
module bird_motion #(
   parameter int Y_W      = 10,
   parameter int VEL_W    = 6,
   parameter int Y_INIT   = 240,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 464,
   parameter int GRAVITY  = 1,
   parameter int VMAX     = 8,
   parameter int FLAP_VEL = -8
) (
   input  logic                    iClk,
   input  logic                    iRstN,
   input  logic                    iBirdRst,
   input  logic                    iBirdWait,
   input  logic                    iFrameTick,
   input  logic                    iFlapPressed,
   input  logic                    iPipeHit,
   output logic [Y_W-1:0]          oBirdY,
   output logic signed [VEL_W-1:0] oBirdVel,
   output logic                    oBirdDead
);

   // Position sum needs a sign bit plus one overflow bit above Y_W.
   localparam int unsigned YS_W = Y_W + 2;
   // Velocity increment needs one guard bit before saturation.
   localparam int unsigned VS_W = VEL_W + 1;

   typedef enum logic [1:0] {
      S_ALIVE    = 2'd0,
      S_DYING    = 2'd1,
      S_GROUNDED = 2'd2
   } state_t;

   state_t                  state, stateNext;
   logic                    flapPending, flapPendingNext;
   logic [Y_W-1:0]          birdYNext;
   logic signed [VEL_W-1:0] birdVelNext;
   logic                    birdDeadNext;

   logic                    flapEff;
   logic signed [VS_W-1:0]  velInc;
   logic signed [VEL_W-1:0] velGrav;
   logic signed [VEL_W-1:0] velNew;
   logic signed [YS_W-1:0]  ySum;

   // Candidate velocity and position for a frame tick.
   always_comb begin
      flapEff = (state == S_ALIVE) && (flapPending || iFlapPressed);
      velInc  = VS_W'(oBirdVel) + VS_W'(GRAVITY);
      velGrav = (velInc > VS_W'(VMAX)) ? VEL_W'(VMAX) : VEL_W'(velInc);
      velNew  = flapEff ? VEL_W'(FLAP_VEL) : velGrav;
      ySum    = $signed({2'b00, oBirdY}) + YS_W'(velNew);
   end

   // Next-state and next-output logic.
   always_comb begin
      stateNext       = state;
      flapPendingNext = flapPending;
      birdYNext       = oBirdY;
      birdVelNext     = oBirdVel;

      if (iBirdRst) begin
         stateNext       = S_ALIVE;
         flapPendingNext = 1'b0;
         birdYNext       = Y_W'(Y_INIT);
         birdVelNext     = '0;
      end else if (iBirdWait) begin
         // Pause: everything holds, flaps seen during pause are dropped.
         flapPendingNext = 1'b0;
      end else begin
         unique case (state)
            S_ALIVE: begin
               if (iPipeHit) begin
                  stateNext       = S_DYING;
                  birdVelNext     = '0;
                  flapPendingNext = 1'b0;
               end else if (iFrameTick) begin
                  flapPendingNext = 1'b0;
                  if (ySum <= YS_W'(Y_MIN)) begin
                     birdYNext   = Y_W'(Y_MIN);
                     birdVelNext = '0;
                  end else if (ySum >= YS_W'(Y_MAX)) begin
                     birdYNext   = Y_W'(Y_MAX);
                     birdVelNext = '0;
                     stateNext   = S_GROUNDED;
                  end else begin
                     birdYNext   = Y_W'(ySum);
                     birdVelNext = velNew;
                  end
               end else if (iFlapPressed) begin
                  flapPendingNext = 1'b1;
               end
            end
            S_DYING: begin
               flapPendingNext = 1'b0;
               if (iFrameTick) begin
                  if (ySum >= YS_W'(Y_MAX)) begin
                     birdYNext   = Y_W'(Y_MAX);
                     birdVelNext = '0;
                     stateNext   = S_GROUNDED;
                  end else begin
                     birdYNext   = Y_W'(ySum);
                     birdVelNext = velNew;
                  end
               end
            end
            default: begin
               flapPendingNext = 1'b0;
            end
         endcase
      end

      birdDeadNext = (stateNext != S_ALIVE);
   end

   // State and output registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state       <= S_ALIVE;
         flapPending <= 1'b0;
         oBirdY      <= Y_W'(Y_INIT);
         oBirdVel    <= '0;
         oBirdDead   <= 1'b0;
      end else begin
         state       <= stateNext;
         flapPending <= flapPendingNext;
         oBirdY      <= birdYNext;
         oBirdVel    <= birdVelNext;
         oBirdDead   <= birdDeadNext;
      end
   end

endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: directed test-plan scenarios plus randomized play,
// compared against an integer-arithmetic model of the bird physics.
module tb_bird_motion;

   logic              iClk;
   logic              iRstN;
   logic              iBirdRst;
   logic              iBirdWait;
   logic              iFrameTick;
   logic              iFlapPressed;
   logic              iPipeHit;
   logic [9:0]        oBirdY;
   logic signed [5:0] oBirdVel;
   logic              oBirdDead;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model state: plain integers.
   int mY, mVel, mPhase, mPend;   // mPhase: 0 alive, 1 falling dead, 2 on ground

   bird_motion dut (
      .iClk        (iClk),
      .iRstN       (iRstN),
      .iBirdRst    (iBirdRst),
      .iBirdWait   (iBirdWait),
      .iFrameTick  (iFrameTick),
      .iFlapPressed(iFlapPressed),
      .iPipeHit    (iPipeHit),
      .oBirdY      (oBirdY),
      .oBirdVel    (oBirdVel),
      .oBirdDead   (oBirdDead)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic checkVal(input string tag, input int got, input int exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mY = 240; mVel = 0; mPhase = 0; mPend = 0;
   endtask

   // One clock of the game rules, priority rst > wait > hit > tick.
   task automatic modelStep(input bit r, input bit w, input bit t, input bit f, input bit h);
      int v, yn;
      if (r) begin
         modelReset();
      end else if (w) begin
         mPend = 0;
      end else if (mPhase == 0) begin
         if (h) begin
            mPhase = 1; mVel = 0; mPend = 0;
         end else if (t) begin
            v  = (mPend != 0 || f) ? -8 : ((mVel + 1 > 8) ? 8 : mVel + 1);
            yn = mY + v;
            mPend = 0;
            if (yn <= 0)        begin mY = 0;   mVel = 0; end
            else if (yn >= 464) begin mY = 464; mVel = 0; mPhase = 2; end
            else                begin mY = yn;  mVel = v; end
         end else if (f) begin
            mPend = 1;
         end
      end else if (mPhase == 1 && t) begin
         v  = (mVel + 1 > 8) ? 8 : mVel + 1;
         yn = mY + v;
         if (yn >= 464) begin mY = 464; mVel = 0; mPhase = 2; end
         else           begin mY = yn;  mVel = v; end
      end
   endtask

   task automatic compareModel(input string tag);
      checkVal({tag, ".y"},    int'(oBirdY),    mY);
      checkVal({tag, ".vel"},  int'(oBirdVel),  mVel);
      checkVal({tag, ".dead"}, int'(oBirdDead), (mPhase != 0) ? 1 : 0);
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare.
   task automatic cyc(input bit r, input bit w, input bit t, input bit f, input bit h,
                      input string tag);
      @(negedge iClk);
      iBirdRst = r; iBirdWait = w; iFrameTick = t; iFlapPressed = f; iPipeHit = h;
      @(posedge iClk);
      modelStep(r, w, t, f, h);
      #1;
      compareModel(tag);
   endtask

   initial begin
      int guard;
      iRstN = 1'b0; iBirdRst = 0; iBirdWait = 0; iFrameTick = 0;
      iFlapPressed = 0; iPipeHit = 0;
      modelReset();
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      iRstN = 1'b1;
      #1;
      checkVal("reset.y",    int'(oBirdY),    240);
      checkVal("reset.vel",  int'(oBirdVel),  0);
      checkVal("reset.dead", int'(oBirdDead), 0);

      // Free fall.
      cyc(0,0,1,0,0,"fall1"); checkVal("fall1.vel", int'(oBirdVel), 1); checkVal("fall1.y", int'(oBirdY), 241);
      cyc(0,0,1,0,0,"fall2"); checkVal("fall2.vel", int'(oBirdVel), 2); checkVal("fall2.y", int'(oBirdY), 243);
      cyc(0,0,1,0,0,"fall3"); checkVal("fall3.vel", int'(oBirdVel), 3); checkVal("fall3.y", int'(oBirdY), 246);

      // Flap latched five cycles before the tick.
      cyc(0,0,0,1,0,"flapset");
      repeat (4) cyc(0,0,0,0,0,"flaphold");
      cyc(0,0,1,0,0,"flap");  checkVal("flap.vel", int'(oBirdVel), -8); checkVal("flap.y", int'(oBirdY), 238);
      cyc(0,0,1,0,0,"flap2"); checkVal("flap2.vel", int'(oBirdVel), -7); checkVal("flap2.y", int'(oBirdY), 231);

      // Flap during pause is discarded; tick during pause ignored.
      cyc(0,1,1,1,0,"waitflap"); checkVal("waitflap.y", int'(oBirdY), 231);
      cyc(0,0,1,0,0,"postwait"); checkVal("postwait.vel", int'(oBirdVel), -6); checkVal("postwait.y", int'(oBirdY), 225);

      // Hit together with tick: dead, position holds, velocity zero.
      cyc(0,0,1,0,1,"hit");
      checkVal("hit.dead", int'(oBirdDead), 1); checkVal("hit.y", int'(oBirdY), 225); checkVal("hit.vel", int'(oBirdVel), 0);
      cyc(0,0,1,1,0,"dying1"); checkVal("dying1.y", int'(oBirdY), 226);
      cyc(0,0,1,0,0,"dying2"); checkVal("dying2.y", int'(oBirdY), 228);
      cyc(0,1,1,0,0,"dyingwait"); checkVal("dyingwait.y", int'(oBirdY), 228);

      // Respawn mid-fall overrides tick, hit and flap; pending flag cleared.
      cyc(1,0,1,1,1,"respawn");
      checkVal("respawn.y", int'(oBirdY), 240); checkVal("respawn.dead", int'(oBirdDead), 0);
      cyc(0,0,1,0,0,"postrsp"); checkVal("postrsp.vel", int'(oBirdVel), 1); checkVal("postrsp.y", int'(oBirdY), 241);

      // Fall to the ground while alive.
      guard = 0;
      while (oBirdY != 10'd464 && guard < 200) begin
         cyc(0,0,1,0,0,"toground");
         guard++;
      end
      checkVal("ground.reached", (guard < 200) ? 1 : 0, 1);
      checkVal("ground.y", int'(oBirdY), 464);
      checkVal("ground.dead", int'(oBirdDead), 1);
      repeat (4) cyc(0,0,1,1,0,"grounded");
      checkVal("grounded.y", int'(oBirdY), 464);
      checkVal("grounded.vel", int'(oBirdVel), 0);

      // Asynchronous reset acts between edges.
      cyc(1,0,0,0,0,"prearst");
      cyc(0,0,1,0,0,"prearst2");
      @(negedge iClk);
      iFrameTick = 0;
      #2 iRstN = 1'b0;
      #1;
      modelReset();
      compareModel("arst");
      @(negedge iClk);
      iRstN = 1'b1;

      // Randomized play.
      for (int i = 0; i < 4000; i++) begin
         bit r, w, t, f, h;
         r = ($urandom_range(0, 199) == 0);
         w = ($urandom_range(0, 14) == 0);
         t = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 6) == 0);
         h = ($urandom_range(0, 59) == 0);
         cyc(r, w, t, f, h, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nErrors);
      $finish;
   end

endmodule
